// File: rtl/trap_ctrl.sv
// Trap/interrupt sequencer feeding the CSR unit's shared write port.
// Optional button debounce: define TRAP_BTN_DEBOUNCE_EN.
module trap_ctrl #(
    parameter int          XLEN       = 32,
    parameter int unsigned DEB_CYCLES = 20'd1000000,
    parameter int          DEB_W      = 20
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            exc_ebreak,
    input  logic            exc_div0,
    input  logic            exc_mem,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_info,
    input  logic            mret,
    input  logic            sw_we,
    input  logic [11:0]     sw_addr,
    input  logic [XLEN-1:0] sw_wdata,
    input  logic [4:0]      btn,
    input  logic [XLEN-1:0] mtevc_dout,
    input  logic [XLEN-1:0] mcause_dout,
    input  logic [XLEN-1:0] mepc_dout,
    input  logic [XLEN-1:0] mtval_dout,
    input  logic [XLEN-1:0] mipd_dout,
    input  logic [XLEN-1:0] bs_dout,
    output logic            csr_we,
    output logic [XLEN-1:0] mtevc_din,
    output logic [XLEN-1:0] mcause_din,
    output logic [XLEN-1:0] mepc_din,
    output logic [XLEN-1:0] mtval_din,
    output logic [XLEN-1:0] mipd_din,
    output logic [XLEN-1:0] bs_din,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            in_trap,
    output logic            trap_lost
);

    typedef enum logic {S_IDLE, S_HANDLER} state_t;

    state_t          r_state;
    logic [4:0]      r_sync1, r_sync2;
    logic [2:0]      w_bcode;
    logic            r_csr_we, r_redirect, r_in_trap, r_trap_lost;
    logic [XLEN-1:0] r_mtevc, r_mcause, r_mepc, r_mtval, r_mipd, r_bs;
    logic [XLEN-1:0] r_rpc;

    function automatic logic [2:0] f_enc(input logic [4:0] b);
        if (b[0])      return 3'd1;
        else if (b[1]) return 3'd2;
        else if (b[2]) return 3'd3;
        else if (b[3]) return 3'd4;
        else if (b[4]) return 3'd5;
        else           return 3'd0;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef TRAP_BTN_DEBOUNCE_EN
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

    logic [4:0]       r_deb_vec;
    logic [DEB_W-1:0] r_deb_cnt;
    logic [2:0]       r_bcode;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_deb_vec <= '0;
            r_deb_cnt <= '0;
            r_bcode   <= '0;
        end else if (r_sync2 != r_deb_vec) begin
            r_deb_vec <= r_sync2;
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != DEB_MAX) begin
            r_deb_cnt <= r_deb_cnt + 1'b1;
        end else begin
            r_bcode   <= f_enc(r_deb_vec);
        end
    end

    assign w_bcode = r_bcode;
`else
    assign w_bcode = f_enc(r_sync2);
`endif

    // A write issued last cycle is not yet visible on dout; forward it.
    logic [XLEN-1:0] w_cur_mtevc, w_cur_mcause, w_cur_mepc;
    logic [XLEN-1:0] w_cur_mtval, w_cur_mipd, w_cur_bs;

    assign w_cur_mtevc  = r_csr_we ? r_mtevc  : mtevc_dout;
    assign w_cur_mcause = r_csr_we ? r_mcause : mcause_dout;
    assign w_cur_mepc   = r_csr_we ? r_mepc   : mepc_dout;
    assign w_cur_mtval  = r_csr_we ? r_mtval  : mtval_dout;
    assign w_cur_mipd   = r_csr_we ? r_mipd   : mipd_dout;
    assign w_cur_bs     = r_csr_we ? r_bs     : bs_dout;

    logic            w_exc, w_trap, w_ret, w_sw_hit, w_sw_ok, w_bs_chg, w_we;
    logic [XLEN-1:0] w_cause, w_bcode_x;
    logic [XLEN-1:0] w_nx_mtevc, w_nx_mcause, w_nx_mepc;
    logic [XLEN-1:0] w_nx_mtval, w_nx_mipd, w_nx_bs;

    assign w_exc     = exc_ebreak | exc_div0 | exc_mem;
    assign w_trap    = (r_state == S_IDLE) && w_exc;
    assign w_ret     = (r_state == S_HANDLER) && mret;
    assign w_bcode_x = {{(XLEN-3){1'b0}}, w_bcode};
    assign w_bs_chg  = (w_bcode_x != w_cur_bs);
    assign w_sw_ok   = sw_we && w_sw_hit && !w_trap;
    assign w_we      = w_trap | w_ret | w_sw_ok | w_bs_chg;

    always_comb begin
        w_cause = XLEN'(1);
        if (exc_mem)       w_cause = XLEN'(3);
        else if (exc_div0) w_cause = XLEN'(2);
    end

    always_comb begin
        w_sw_hit    = 1'b1;
        w_nx_mtevc  = w_cur_mtevc;
        w_nx_mcause = w_cur_mcause;
        w_nx_mepc   = w_cur_mepc;
        w_nx_mtval  = w_cur_mtval;
        w_nx_mipd   = w_cur_mipd;
        w_nx_bs     = w_bcode_x;
        case (sw_addr)
            12'h305: if (w_sw_ok) w_nx_mtevc  = sw_wdata;
            12'h342: if (w_sw_ok) w_nx_mcause = sw_wdata;
            12'h341: if (w_sw_ok) w_nx_mepc   = sw_wdata;
            12'h343: if (w_sw_ok) w_nx_mtval  = sw_wdata;
            12'h100: if (w_sw_ok) w_nx_mipd   = sw_wdata;
            12'h000: if (w_sw_ok) w_nx_bs     = sw_wdata;
            default: w_sw_hit = 1'b0;
        endcase
        if (w_trap) begin
            w_nx_mcause = w_cause;
            w_nx_mepc   = exc_pc;
            w_nx_mtval  = exc_info;
            w_nx_mipd   = '0;
        end
        if (w_ret) w_nx_mipd = XLEN'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_csr_we    <= 1'b0;
            r_redirect  <= 1'b0;
            r_rpc       <= '0;
            r_in_trap   <= 1'b0;
            r_trap_lost <= 1'b0;
            r_mtevc     <= '0;
            r_mcause    <= '0;
            r_mepc      <= '0;
            r_mtval     <= '0;
            r_mipd      <= '0;
            r_bs        <= '0;
        end else begin
            r_csr_we    <= w_we;
            r_mtevc     <= w_nx_mtevc;
            r_mcause    <= w_nx_mcause;
            r_mepc      <= w_nx_mepc;
            r_mtval     <= w_nx_mtval;
            r_mipd      <= w_nx_mipd;
            r_bs        <= w_nx_bs;
            r_redirect  <= 1'b0;
            r_trap_lost <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_trap <= 1'b0;
                    if (w_exc) begin
                        r_state    <= S_HANDLER;
                        r_in_trap  <= 1'b1;
                        r_redirect <= 1'b1;
                        r_rpc      <= w_cur_mtevc;
                    end
                end
                S_HANDLER: begin
                    r_in_trap   <= 1'b1;
                    r_trap_lost <= w_exc;
                    if (mret) begin
                        r_state    <= S_IDLE;
                        r_in_trap  <= 1'b0;
                        r_redirect <= 1'b1;
                        r_rpc      <= w_cur_mepc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign csr_we      = r_csr_we;
    assign mtevc_din   = r_mtevc;
    assign mcause_din  = r_mcause;
    assign mepc_din    = r_mepc;
    assign mtval_din   = r_mtval;
    assign mipd_din    = r_mipd;
    assign bs_din      = r_bs;
    assign redirect    = r_redirect;
    assign redirect_pc = r_rpc;
    assign in_trap     = r_in_trap;
    assign trap_lost   = r_trap_lost;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl with a behavioural CSR register file.
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        exc_ebreak, exc_div0, exc_mem, mret, sw_we;
    logic [31:0] exc_pc, exc_info, sw_wdata;
    logic [11:0] sw_addr;
    logic [4:0]  btn;
    logic [31:0] m_mtevc, m_mcause, m_mepc, m_mtval, m_mipd, m_bs;
    logic        csr_we, redirect, in_trap, trap_lost;
    logic [31:0] mtevc_din, mcause_din, mepc_din, mtval_din, mipd_din, bs_din;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.XLEN(32), .DEB_CYCLES(8), .DEB_W(20)) dut (
        .clk(clk), .rstn(rstn),
        .exc_ebreak(exc_ebreak), .exc_div0(exc_div0), .exc_mem(exc_mem),
        .exc_pc(exc_pc), .exc_info(exc_info), .mret(mret),
        .sw_we(sw_we), .sw_addr(sw_addr), .sw_wdata(sw_wdata), .btn(btn),
        .mtevc_dout(m_mtevc), .mcause_dout(m_mcause), .mepc_dout(m_mepc),
        .mtval_dout(m_mtval), .mipd_dout(m_mipd), .bs_dout(m_bs),
        .csr_we(csr_we),
        .mtevc_din(mtevc_din), .mcause_din(mcause_din), .mepc_din(mepc_din),
        .mtval_din(mtval_din), .mipd_din(mipd_din), .bs_din(bs_din),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .in_trap(in_trap), .trap_lost(trap_lost)
    );

    always #5 clk = ~clk;

    // CSR unit: all six registers load on the shared strobe.
    initial begin
        m_mtevc = 0; m_mcause = 0; m_mepc = 0;
        m_mtval = 0; m_mipd = 0; m_bs = 0;
    end
    always @(posedge clk) begin
        if (csr_we) begin
            m_mtevc  <= mtevc_din;
            m_mcause <= mcause_din;
            m_mepc   <= mepc_din;
            m_mtval  <= mtval_din;
            m_mipd   <= mipd_din;
            m_bs     <= bs_din;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        exc_ebreak = 0; exc_div0 = 0; exc_mem = 0; mret = 0;
        sw_we = 0; sw_addr = 0; sw_wdata = 0;
    endtask

    task automatic wait_we(input string tag, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (csr_we) seen = 1;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        bit any;
        idle_in();
        exc_pc = 0; exc_info = 0; btn = 0;
        rstn = 0;
        tick(); tick();
        chk("rst_we", 32'(csr_we), 0);
        chk("rst_redir", 32'(redirect), 0);
        chk("rst_intrap", 32'(in_trap), 0);
        chk("rst_lost", 32'(trap_lost), 0);
        chk("rst_mcause", mcause_din, 0);
        chk("rst_rpc", redirect_pc, 0);
        rstn = 1;
        tick();

        sw_we = 1; sw_addr = 12'h305; sw_wdata = 32'h100;
        tick(); idle_in();
        chk("sw_mtevc_we", 32'(csr_we), 1);
        chk("sw_mtevc", mtevc_din, 32'h100);
        tick();
        chk("sw_done_we", 32'(csr_we), 0);

        exc_div0 = 1; exc_pc = 32'h40; exc_info = 32'h7;
        tick(); idle_in();
        chk("div0_we", 32'(csr_we), 1);
        chk("div0_cause", mcause_din, 2);
        chk("div0_mepc", mepc_din, 32'h40);
        chk("div0_mtval", mtval_din, 32'h7);
        chk("div0_mipd", mipd_din, 0);
        chk("div0_mtevc", mtevc_din, 32'h100);
        chk("div0_redir", 32'(redirect), 1);
        chk("div0_rpc", redirect_pc, 32'h100);
        chk("div0_intrap", 32'(in_trap), 1);
        tick();
        chk("hdl_redir", 32'(redirect), 0);
        chk("hdl_we", 32'(csr_we), 0);

        exc_ebreak = 1;
        tick(); idle_in();
        chk("lost_pulse", 32'(trap_lost), 1);
        chk("lost_we", 32'(csr_we), 0);
        chk("lost_intrap", 32'(in_trap), 1);
        tick();
        chk("lost_end", 32'(trap_lost), 0);

        mret = 1;
        tick(); idle_in();
        chk("mret_we", 32'(csr_we), 1);
        chk("mret_mipd", mipd_din, 1);
        chk("mret_cause", mcause_din, 2);
        chk("mret_redir", 32'(redirect), 1);
        chk("mret_rpc", redirect_pc, 32'h40);
        chk("mret_intrap", 32'(in_trap), 0);
        tick();
        mret = 1;
        tick(); idle_in();
        chk("mret_idle_redir", 32'(redirect), 0);
        chk("mret_idle_we", 32'(csr_we), 0);

        exc_mem = 1; exc_div0 = 1; exc_ebreak = 1;
        exc_pc = 32'h80; exc_info = 32'h11;
        tick(); idle_in();
        chk("prio_cause", mcause_din, 3);
        chk("prio_mepc", mepc_din, 32'h80);
        tick();
        mret = 1; exc_mem = 1;
        tick(); idle_in();
        chk("mret_exc_redir", 32'(redirect), 1);
        chk("mret_exc_rpc", redirect_pc, 32'h80);
        chk("mret_exc_lost", 32'(trap_lost), 1);
        chk("mret_exc_intrap", 32'(in_trap), 0);
        tick();

        exc_ebreak = 1; exc_pc = 32'hC0; exc_info = 32'h55;
        sw_we = 1; sw_addr = 12'h343; sw_wdata = 32'hDEAD;
        tick(); idle_in();
        chk("swdrop_cause", mcause_din, 1);
        chk("swdrop_mtval", mtval_din, 32'h55);
        tick();
        mret = 1; sw_we = 1; sw_addr = 12'h342; sw_wdata = 32'h9;
        tick(); idle_in();
        chk("merge_cause", mcause_din, 32'h9);
        chk("merge_mipd", mipd_din, 1);
        chk("merge_rpc", redirect_pc, 32'hC0);
        tick();

        sw_we = 1; sw_addr = 12'h123; sw_wdata = 32'h77;
        tick(); idle_in();
        chk("sw_unknown_we", 32'(csr_we), 0);

        btn = 5'b00101;
        tick();
        chk("btn_early_we", 32'(csr_we), 0);
`ifdef TRAP_BTN_DEBOUNCE_EN
        wait_we("btn_we", 20);
`else
        wait_we("btn_we", 3);
`endif
        chk("btn_code", bs_din, 1);
        tick(); tick();
`ifdef TRAP_BTN_DEBOUNCE_EN
        btn = 5'b00010;
        tick(); tick(); tick();
        btn = 5'b00101;
        any = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (csr_we) any = 1;
        end
        chk("glitch_no_we", 32'(any), 0);
`endif
        btn = 5'b00000;
        wait_we("btn_rel_we", 20);
        chk("btn_rel_code", bs_din, 0);
        tick(); tick();

        exc_ebreak = 1; exc_pc = 32'h200;
        tick(); idle_in();
        chk("rst_mid_intrap", 32'(in_trap), 1);
        #2 rstn = 0;
        #1;
        chk("arst_intrap", 32'(in_trap), 0);
        chk("arst_redir", 32'(redirect), 0);
        chk("arst_we", 32'(csr_we), 0);
        chk("arst_mepc", mepc_din, 0);
        chk("arst_rpc", redirect_pc, 0);
        tick(); tick();
        rstn = 1;
        mret = 1;
        tick(); idle_in();
        chk("post_rst_redir", 32'(redirect), 0);
        chk("post_rst_we", 32'(csr_we), 0);
        chk("post_rst_intrap", 32'(in_trap), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
